// File: rtl/fifo_rd_stream_adapter.sv
// Read-side consumer for an async FIFO: issues rd_en against empty, captures data one cycle
// later into a small circular prefetch buffer, and re-presents words as a valid/ready stream.
module fifo_rd_stream_adapter #(
  parameter  int DATA_WIDTH = 8,
  parameter  int BUF_DEPTH  = 3,
  parameter  int CNT_WIDTH  = 16,
  localparam int OCC_W      = $clog2(BUF_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  flush,
  output logic [OCC_W-1:0]      occupancy,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic                  state_dbg
);

  localparam int IDX_W = $clog2(BUF_DEPTH);
  localparam logic [OCC_W:0]   DEPTH_LV = (OCC_W + 1)'(BUF_DEPTH);
  localparam logic [OCC_W-1:0] FULL_LV  = OCC_W'(BUF_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUF_DEPTH - 1);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [OCC_W-1:0]      occ_q;
  logic                  inflight;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [OCC_W:0]        level;
  logic                  capture, pop;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
  endfunction

  // Stream handshake: a word transfers on every clk edge where m_valid and m_ready are both
  // high; m_valid never waits on m_ready and m_data holds steady until that transfer.
  assign level     = {1'b0, occ_q} + (OCC_W + 1)'(inflight);
  assign m_valid   = (occ_q != '0);
  assign m_data    = buf_mem[rd_idx];
  assign occupancy = occ_q;
  assign word_count = cnt_q;
  assign state_dbg = state_q;
  assign capture   = inflight && (state_q == ST_RUN) && !flush;
  assign pop       = m_valid && m_ready && (state_q == ST_RUN) && !flush;

  // Read issue uses only registered terms plus the flags, so m_ready never reaches rd_en.
  always_comb begin
    state_d    = state_q;
    fifo_rd_en = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (flush) state_d = ST_FLUSH;
        fifo_rd_en = rst_n && !fifo_empty && !flush && (level < DEPTH_LV);
      end
      ST_FLUSH: begin
        if (!flush) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      wr_idx   <= '0;
      rd_idx   <= '0;
      occ_q    <= '0;
      inflight <= 1'b0;
      cnt_q    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) buf_mem[i] <= '0;
    end else begin
      state_q  <= state_d;
      inflight <= fifo_rd_en;
      if (state_q == ST_RUN && flush) begin
        occ_q  <= '0;
        wr_idx <= '0;
        rd_idx <= '0;
      end else begin
        if (capture) begin
          buf_mem[wr_idx] <= fifo_data;
          wr_idx          <= next_idx(wr_idx);
        end
        if (pop) begin
          rd_idx <= next_idx(rd_idx);
          cnt_q  <= cnt_q + CNT_WIDTH'(1);
        end
        case ({capture, pop})
          2'b10:   occ_q <= occ_q + OCC_W'(1);
          2'b01:   occ_q <= occ_q - OCC_W'(1);
          default: occ_q <= occ_q;
        endcase
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(capture && occ_q == FULL_LV));

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench for fifo_rd_stream_adapter: FIFO read-port model, per-cycle vector table,
// hand-written flush/stream/random/wrap sequences and an in-order scoreboard.
module tb_fifo_rd_stream_adapter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (CNT_WIDTH=16)
  logic       rst_n, fifo_rd_en, m_valid, m_ready, flush, state_dbg;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data  = 8'h00;
  logic [7:0] m_data;
  logic [1:0] occupancy;
  logic [15:0] word_count;

  // Wrap instance (CNT_WIDTH=4)
  logic       rst2_n, fifo2_empty, fifo2_rd_en, m2_valid, m2_ready, flush2, state2_dbg;
  logic [7:0] fifo2_data = 8'h00;
  logic [7:0] f2_cnt     = 8'h00;
  logic [7:0] m2_data;
  logic [1:0] occupancy2;
  logic [3:0] word_count2;

  fifo_rd_stream_adapter #(.DATA_WIDTH(8), .BUF_DEPTH(3), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .flush(flush), .occupancy(occupancy), .word_count(word_count), .state_dbg(state_dbg)
  );

  fifo_rd_stream_adapter #(.DATA_WIDTH(8), .BUF_DEPTH(3), .CNT_WIDTH(4)) dut2 (
    .clk(clk), .rst_n(rst2_n), .fifo_empty(fifo2_empty), .fifo_data(fifo2_data),
    .fifo_rd_en(fifo2_rd_en), .m_valid(m2_valid), .m_ready(m2_ready), .m_data(m2_data),
    .flush(flush2), .occupancy(occupancy2), .word_count(word_count2), .state_dbg(state2_dbg)
  );

  // FIFO read-port model: registered empty flag, data valid the cycle after a read.
  logic [7:0] fmem [256];
  logic [7:0] wp = 8'h00;
  logic [7:0] rp = 8'h00;
  logic       force_empty, fifo_clear;
  logic       inflight_m = 1'b0;

  always @(posedge clk) begin : fifo_model
    logic [7:0] rp_n;
    rp_n = rp;
    if (fifo_clear) rp_n = wp;
    else if (fifo_rd_en && !fifo_empty) begin
      fifo_data <= fmem[rp];
      rp_n = rp + 8'd1;
    end
    rp         <= rp_n;
    fifo_empty <= force_empty || (rp_n == wp);
    inflight_m <= fifo_rd_en && !fifo_empty;
  end

  always @(posedge clk) begin : fifo2_model
    if (fifo2_rd_en && !fifo2_empty) begin
      fifo2_data <= f2_cnt;
      f2_cnt     <= f2_cnt + 8'd1;
    end
  end

  // Scoreboard and counters
  logic [7:0] exp_q[$];
  int passed = 0;
  int total  = 0;
  int viol   = 0;
  logic sb_on;

  typedef struct packed {
    logic       m_ready;
    logic       exp_rd;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [1:0] exp_occ;
  } vec_t;
  vec_t vec [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d, input logic to_sb);
    fmem[wp] = d;
    wp = wp + 8'd1;
    if (to_sb) exp_q.push_back(d);
  endtask

  // Called at a negedge after inputs are driven; the pop happens at the next posedge.
  task automatic observe();
    #1;
    if (fifo_rd_en && (int'(occupancy) + int'(inflight_m)) >= 3) viol++;
    if (sb_on && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL sb_unexpected: got 0x%0h, required no word", m_data);
      end else begin
        chk("sb_order", m_data, exp_q.pop_front());
      end
    end
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n, delivered, duty;
    int first_rd, first_valid, first_pop, last_pop;

    // {m_ready, exp_rd_en, exp_m_valid, exp_m_data, exp_occupancy}, one entry per cycle
    vec[0]  = '{1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
    vec[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
    vec[2]  = '{1'b0, 1'b1, 1'b1, 8'h01, 2'd1};
    vec[3]  = '{1'b0, 1'b0, 1'b1, 8'h01, 2'd2};
    vec[4]  = '{1'b0, 1'b0, 1'b1, 8'h01, 2'd3};
    vec[5]  = '{1'b0, 1'b0, 1'b1, 8'h01, 2'd3};
    vec[6]  = '{1'b1, 1'b0, 1'b1, 8'h01, 2'd3};
    vec[7]  = '{1'b1, 1'b1, 1'b1, 8'h02, 2'd2};
    vec[8]  = '{1'b1, 1'b1, 1'b1, 8'h03, 2'd1};
    vec[9]  = '{1'b1, 1'b1, 1'b1, 8'h04, 2'd1};
    vec[10] = '{1'b1, 1'b1, 1'b1, 8'h05, 2'd1};
    vec[11] = '{1'b1, 1'b1, 1'b1, 8'h06, 2'd1};
    vec[12] = '{1'b1, 1'b0, 1'b1, 8'h07, 2'd1};
    vec[13] = '{1'b1, 1'b0, 1'b1, 8'h08, 2'd1};
    vec[14] = '{1'b1, 1'b0, 1'b0, 8'h00, 2'd0};

    rst_n = 1'b0; m_ready = 1'b0; flush = 1'b0; force_empty = 1'b0; fifo_clear = 1'b0;
    rst2_n = 1'b0; fifo2_empty = 1'b1; m2_ready = 1'b0; flush2 = 1'b0; sb_on = 1'b0;
    @(negedge clk);

    // T1: reset held with a non-empty FIFO and m_ready=1
    for (int i = 1; i <= 8; i++) push(8'(i), 1'b0);
    tick();
    m_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      #1;
      chk("t1_rd_en", fifo_rd_en, 0);
      chk("t1_m_valid", m_valid, 0);
      chk("t1_word_count", word_count, 0);
      chk("t1_occupancy", occupancy, 0);
    end

    // T3: backpressure then drain, cycle by cycle from reset release
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      m_ready = vec[k].m_ready;
      #1;
      chk($sformatf("t3_rd_en[%0d]", k), fifo_rd_en, vec[k].exp_rd);
      chk($sformatf("t3_m_valid[%0d]", k), m_valid, vec[k].exp_valid);
      chk($sformatf("t3_occ[%0d]", k), occupancy, vec[k].exp_occ);
      if (vec[k].exp_valid) chk($sformatf("t3_m_data[%0d]", k), m_data, vec[k].exp_data);
      tick();
    end
    chk("t3_word_count", word_count, 8);

    // T5: flush with two buffered words and one in flight
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h41 + 8'(i), 1'b0);
    n = 0;
    while (occupancy != 2'd2 && n < 20) begin tick(); n++; end
    chk("t5_reach_occ2", occupancy, 2);
    chk("t5_head", m_data, 8'h41);
    flush = 1'b1;
    #1 chk("t5_rd_en_flush", fifo_rd_en, 0);
    tick();
    flush = 1'b0;
    #1;
    chk("t5_valid_c1", m_valid, 0);
    chk("t5_state_flush", state_dbg, 1);
    chk("t5_rd_en_c1", fifo_rd_en, 0);
    tick();
    #1;
    chk("t5_valid_c2", m_valid, 0);
    chk("t5_state_run", state_dbg, 0);
    chk("t5_rd_en_c2", fifo_rd_en, 1);
    chk("t5_wc_kept", word_count, 8);
    for (int i = 3; i < 8; i++) exp_q.push_back(8'h41 + 8'(i));
    sb_on = 1'b1;
    m_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin observe(); tick(); n++; end
    chk("t5_drained", exp_q.size(), 0);
    chk("t5_word_count", word_count, 13);

    // T2: streaming 16 words from reset
    rst_n = 1'b0;
    fifo_clear = 1'b1;
    tick();
    fifo_clear = 1'b0;
    for (int i = 1; i <= 16; i++) push(8'(i), 1'b1);
    tick();
    #1 chk("t2_wc_reset", word_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1'b1;
    first_rd = -1; first_valid = -1; first_pop = -1; last_pop = -1;
    for (int t = 0; t < 60 && exp_q.size() != 0; t++) begin
      observe();
      if (fifo_rd_en && first_rd < 0) first_rd = t;
      if (m_valid && first_valid < 0) first_valid = t;
      if (m_valid && m_ready) begin
        if (first_pop < 0) first_pop = t;
        last_pop = t;
      end
      tick();
    end
    chk("t2_drained", exp_q.size(), 0);
    chk("t2_valid_latency", first_valid - first_rd, 2);
    chk("t2_back_to_back", last_pop - first_pop, 15);
    chk("t2_word_count", word_count, 16);

    // T4: random FIFO gaps and m_ready duty
    viol = 0;
    duty = 100;
    for (int c = 0; c < 10000; c++) begin
      if (c % 500 == 0) duty = $urandom_range(30, 100);
      if ($urandom_range(0, 3) != 0 && (wp - rp) < 8'd200) push(8'($urandom_range(0, 255)), 1'b1);
      force_empty = ($urandom_range(0, 9) < 2);
      m_ready = ($urandom_range(1, 100) <= duty);
      observe();
      tick();
    end
    force_empty = 1'b0;
    m_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin observe(); tick(); n++; end
    chk("t4_drained", exp_q.size(), 0);
    chk("t4_rd_en_limit", viol, 0);

    // Flush held two cycles keeps FLUSH one extra cycle
    flush = 1'b1;
    tick();
    #1 chk("flush2_state_a", state_dbg, 1);
    tick();
    #1 chk("flush2_state_b", state_dbg, 1);
    flush = 1'b0;
    tick();
    #1 chk("flush2_state_run", state_dbg, 0);

    // T6: empty FIFO at release, then counter wrap at 4 bits, then mid-stream reset
    @(negedge clk);
    rst2_n = 1'b1;
    m2_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      chk("t6_idle_rd_en", fifo2_rd_en, 0);
      chk("t6_idle_valid", m2_valid, 0);
    end
    @(negedge clk);
    fifo2_empty = 1'b0;
    delivered = 0;
    n = 0;
    while (delivered < 18 && n < 100) begin
      #1;
      if (m2_valid && m2_ready) begin
        chk("t6_data", m2_data, 8'(delivered));
        delivered++;
      end
      tick();
      n++;
    end
    m2_ready = 1'b0;
    #1 chk("t6_wrap_count", word_count2, 2);
    @(negedge clk);
    m2_ready = 1'b1;
    tick();
    tick();
    rst2_n = 1'b0;
    #1 chk("t6_rst_rd_en", fifo2_rd_en, 0);
    tick();
    #1;
    chk("t6_rst_valid", m2_valid, 0);
    chk("t6_rst_occ", occupancy2, 0);
    chk("t6_rst_count", word_count2, 0);
    chk("t6_rst_state", state2_dbg, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
